// File: rtl/power_seq_pkg.sv
// Shared types and helpers for the power-load sequencer: FSM state encoding,
// LED state codes and the saturating level-step function.
package power_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RAMP_UP   = 3'd1,
      ST_HOLD      = 3'd2,
      ST_RAMP_DOWN = 3'd3,
      ST_DONE      = 3'd4
   } pwr_seq_state_t;

   localparam logic [1:0] LED_IDLE      = 2'd0;
   localparam logic [1:0] LED_RAMP_UP   = 2'd1;
   localparam logic [1:0] LED_HOLD      = 2'd2;
   localparam logic [1:0] LED_RAMP_DOWN = 2'd3;

   // DONE is a one-cycle transient and shows as IDLE on the board LEDs.
   function automatic logic [1:0] led_code(input pwr_seq_state_t s);
      case (s)
         ST_RAMP_UP:   return LED_RAMP_UP;
         ST_HOLD:      return LED_HOLD;
         ST_RAMP_DOWN: return LED_RAMP_DOWN;
         default:      return LED_IDLE;
      endcase
   endfunction

   // Wide arithmetic so level+step can never wrap before the clamp.
   function automatic int unsigned lvl_next(input int unsigned lvl,
                                            input int unsigned step,
                                            input int unsigned tgt,
                                            input logic        up);
      int unsigned sum;
      sum = lvl + step;
      if (up) return (sum > tgt) ? tgt : sum;
      return (step >= lvl) ? 32'd0 : lvl - step;
   endfunction

endpackage

// File: rtl/pwr_therm_enc.sv
// Combinational level-to-thermometer encoder: bit i is set when i < level.
module pwr_therm_enc #(
   parameter int NUM_GROUPS = 16,
   parameter int LVL_W      = $clog2(NUM_GROUPS + 1)
) (
   input  logic [LVL_W-1:0]      i_level,
   output logic [NUM_GROUPS-1:0] o_mask
);

   always_comb begin
      o_mask = '0;
      for (int i = 0; i < NUM_GROUPS; i++) begin
         o_mask[i] = (i < int'(i_level));
      end
   end

endmodule

// File: rtl/power_load_sequencer.sv
// Ramps a thermometer-coded consumer enable mask up to a target, holds, and
// ramps back down. Optional square-wave mode is built only with PWR_SEQ_PULSE_EN.
module power_load_sequencer
   import power_seq_pkg::*;
#(
   parameter int NUM_GROUPS = 16,
   parameter int DWELL_W    = 32,
   parameter int LVL_W      = $clog2(NUM_GROUPS + 1)
) (
   input  logic                  clk_in,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [LVL_W-1:0]      cfg_target,
   input  logic [LVL_W-1:0]      cfg_step,
   input  logic [DWELL_W-1:0]    cfg_dwell,
   input  logic [DWELL_W-1:0]    cfg_hold,
   input  logic [7:0]            cfg_reps,
   input  logic                  cfg_pulse,
   output logic [NUM_GROUPS-1:0] grp_en,
   output logic [LVL_W-1:0]      level,
   output logic                  busy,
   output logic                  done,
   output logic [3:0]            status_led
);

   localparam logic [LVL_W-1:0]   MAX_LVL = LVL_W'(NUM_GROUPS);
   localparam logic [DWELL_W-1:0] ONE_CNT = DWELL_W'(1);

   pwr_seq_state_t        r_state;
   pwr_seq_state_t        w_state_nxt;
   logic [LVL_W-1:0]      r_level,  w_level_nxt;
   logic [NUM_GROUPS-1:0] r_grp_en, w_mask_nxt;
   logic [DWELL_W-1:0]    r_cnt,    w_cnt_nxt;
   logic [7:0]            r_reps,   w_reps_nxt;
   logic [LVL_W-1:0]      r_target, r_step;
   logic [DWELL_W-1:0]    r_dwell,  r_hold;
   logic                  r_done_seen;
   logic                  w_capture;

   logic [LVL_W-1:0]      w_cap_target, w_cap_step, w_cap_step_eff;
   logic [DWELL_W-1:0]    w_cap_dwell, w_cap_hold;
   logic [7:0]            w_cap_reps;
   logic [LVL_W-1:0]      w_lvl_first, w_lvl_up, w_lvl_dn;

   assign w_cap_target = (cfg_target > MAX_LVL) ? MAX_LVL : cfg_target;
   assign w_cap_step   = (cfg_step == '0) ? LVL_W'(1) : cfg_step;
   assign w_cap_dwell  = (cfg_dwell == '0) ? ONE_CNT : cfg_dwell;
   assign w_cap_hold   = (cfg_hold == '0) ? ONE_CNT : cfg_hold;
   assign w_cap_reps   = (cfg_reps == 8'd0) ? 8'd1 : cfg_reps;

`ifdef PWR_SEQ_PULSE_EN
   // A full-width step turns every run into a 0 -> target -> 0 square wave.
   assign w_cap_step_eff = cfg_pulse ? MAX_LVL : w_cap_step;
`else
   logic w_unused_pulse;
   assign w_unused_pulse = cfg_pulse;
   assign w_cap_step_eff = w_cap_step;
`endif

   assign w_lvl_first = LVL_W'(lvl_next(32'd0, 32'(w_cap_step_eff), 32'(w_cap_target), 1'b1));
   assign w_lvl_up    = LVL_W'(lvl_next(32'(r_level), 32'(r_step), 32'(r_target), 1'b1));
   assign w_lvl_dn    = LVL_W'(lvl_next(32'(r_level), 32'(r_step), 32'(r_target), 1'b0));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk_in) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // NOTE: every comb output gets a default first so no path infers a latch.
   always_comb begin
      logic do_down;
      w_state_nxt = r_state;
      w_level_nxt = r_level;
      w_cnt_nxt   = r_cnt;
      w_reps_nxt  = r_reps;
      w_capture   = 1'b0;
      do_down     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_capture   = 1'b1;
               w_reps_nxt  = w_cap_reps;
               w_level_nxt = w_lvl_first;
               if (w_cap_target == '0) begin
                  w_state_nxt = ST_DONE;
               end else if (w_lvl_first == w_cap_target) begin
                  w_state_nxt = ST_HOLD;
                  w_cnt_nxt   = w_cap_hold - ONE_CNT;
               end else begin
                  w_state_nxt = ST_RAMP_UP;
                  w_cnt_nxt   = w_cap_dwell - ONE_CNT;
               end
            end
         end
         ST_RAMP_UP: begin
            if (abort) begin
               w_reps_nxt  = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_RAMP_DOWN;
            end else if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - ONE_CNT;
            end else begin
               w_level_nxt = w_lvl_up;
               if (w_lvl_up == r_target) begin
                  w_state_nxt = ST_HOLD;
                  w_cnt_nxt   = r_hold - ONE_CNT;
               end else begin
                  w_cnt_nxt = r_dwell - ONE_CNT;
               end
            end
         end
         ST_HOLD: begin
            if (abort) begin
               w_reps_nxt  = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_RAMP_DOWN;
            end else if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - ONE_CNT;
            end else begin
               do_down = 1'b1;
            end
         end
         ST_RAMP_DOWN: begin
            if (abort) w_reps_nxt = '0;
            if (r_cnt != '0) w_cnt_nxt = r_cnt - ONE_CNT;
            else             do_down   = 1'b1;
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase

      // The step that lands on zero closes one repetition.
      if (do_down) begin
         w_level_nxt = w_lvl_dn;
         w_cnt_nxt   = r_dwell - ONE_CNT;
         if (w_lvl_dn != '0) begin
            w_state_nxt = ST_RAMP_DOWN;
         end else if (r_reps > 8'd1 && !abort) begin
            w_reps_nxt  = r_reps - 8'd1;
            w_state_nxt = ST_RAMP_UP;
         end else begin
            w_reps_nxt  = '0;
            w_state_nxt = ST_DONE;
         end
      end
   end

   pwr_therm_enc #(
      .NUM_GROUPS (NUM_GROUPS),
      .LVL_W      (LVL_W)
   ) u_therm (
      .i_level (w_level_nxt),
      .o_mask  (w_mask_nxt)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         r_level     <= '0;
         r_grp_en    <= '0;
         r_cnt       <= '0;
         r_reps      <= '0;
         r_target    <= '0;
         r_step      <= '0;
         r_dwell     <= '0;
         r_hold      <= '0;
         r_done_seen <= 1'b0;
      end else begin
         r_level  <= w_level_nxt;
         r_grp_en <= w_mask_nxt;
         r_cnt    <= w_cnt_nxt;
         r_reps   <= w_reps_nxt;
         if (w_capture) begin
            r_target <= w_cap_target;
            r_step   <= w_cap_step_eff;
            r_dwell  <= w_cap_dwell;
            r_hold   <= w_cap_hold;
         end
         if (w_capture)               r_done_seen <= 1'b0;
         else if (r_state == ST_DONE) r_done_seen <= 1'b1;
      end
   end

   always_comb begin
      busy       = (r_state != ST_IDLE);
      done       = (r_state == ST_DONE);
      status_led = {busy, r_done_seen, led_code(r_state)};
   end

   assign level  = r_level;
   assign grp_en = r_grp_en;

endmodule

// File: tb/tb_power_load_sequencer.sv
// Directed bench for power_load_sequencer; expected level sequences are
// hand-built per scenario. Honours PWR_SEQ_PULSE_EN for the pulse scenario.
module tb_power_load_sequencer;

   localparam int NG = 16;
   localparam int DW = 32;
   localparam int LW = 5;

   logic          clk_in = 1'b0;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [LW-1:0] cfg_target;
   logic [LW-1:0] cfg_step;
   logic [DW-1:0] cfg_dwell;
   logic [DW-1:0] cfg_hold;
   logic [7:0]    cfg_reps;
   logic          cfg_pulse;
   logic [NG-1:0] grp_en;
   logic [LW-1:0] level;
   logic          busy;
   logic          done;
   logic [3:0]    status_led;

   int vectors = 0;
   int fails   = 0;
   int exp_q[$];

   power_load_sequencer #(
      .NUM_GROUPS (NG),
      .DWELL_W    (DW)
   ) dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .cfg_target (cfg_target),
      .cfg_step   (cfg_step),
      .cfg_dwell  (cfg_dwell),
      .cfg_hold   (cfg_hold),
      .cfg_reps   (cfg_reps),
      .cfg_pulse  (cfg_pulse),
      .grp_en     (grp_en),
      .level      (level),
      .busy       (busy),
      .done       (done),
      .status_led (status_led)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   function automatic logic [NG-1:0] therm(input int n);
      return NG'((64'd1 << n) - 64'd1);
   endfunction

   task automatic push_n(input int v, input int n);
      repeat (n) exp_q.push_back(v);
   endtask

   task automatic push_walk(input int from, input int to, input int stp, input int n);
      for (int v = from; (stp > 0) ? (v <= to) : (v >= to); v += stp) push_n(v, n);
   endtask

   task automatic set_cfg(input int t, input int s, input int d, input int h,
                          input int r, input logic p);
      cfg_target = LW'(t);
      cfg_step   = LW'(s);
      cfg_dwell  = DW'(d);
      cfg_hold   = DW'(h);
      cfg_reps   = 8'(r);
      cfg_pulse  = p;
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 1'b0);
      repeat (3) tick();
      vectors++;
      if (level !== '0 || grp_en !== '0 || busy !== 1'b0 || done !== 1'b0 || status_led !== 4'b0000) begin
         fails++;
         $display("FAIL reset: level=%0d grp_en=%h busy=%b done=%b led=%b, want all zero",
                  level, grp_en, busy, done, status_led);
      end
      rst_n = 1'b1;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      vectors++;
      if (busy !== 1'b0 || status_led !== 4'b0000) begin
         fails++;
         $display("FAIL idle_abort: busy=%b led=%b, want 0 0000", busy, status_led);
      end
   endtask

   task automatic test_ramp();
      logic e_done;
      set_cfg(10, 3, 4, 8, 1, 1'b0);
      push_walk(3, 9, 3, 4);
      push_n(10, 8);
      push_walk(7, 1, -3, 4);
      push_n(0, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         e_done = (i == exp_q.size() - 1);
         vectors++;
         if (level !== LW'(exp_q[i]) || grp_en !== therm(exp_q[i]) || busy !== 1'b1 || done !== e_done) begin
            fails++;
            $display("FAIL ramp[%0d]: level=%0d grp_en=%h busy=%b done=%b, want %0d %h 1 %b",
                     i, level, grp_en, busy, done, exp_q[i], therm(exp_q[i]), e_done);
         end
         if (i == 14) begin
            vectors++;
            if (grp_en !== 16'h03FF || status_led !== 4'b1010) begin
               fails++;
               $display("FAIL ramp_peak: grp_en=%h led=%b, want 03ff 1010", grp_en, status_led);
            end
         end
         // A start while busy, with altered config, must change nothing.
         if (i == 5) cfg_target = LW'(3);
         start = (i == 5);
         tick();
      end
      start = 1'b0;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || status_led !== 4'b0100) begin
         fails++;
         $display("FAIL ramp_end: busy=%b done=%b led=%b, want 0 0 0100", busy, done, status_led);
      end
   endtask

   task automatic test_clamp();
      logic e_done;
      set_cfg(20, 0, 0, 0, 0, 1'b0);
      push_walk(1, 15, 1, 1);
      push_n(16, 1);
      push_walk(15, 1, -1, 1);
      push_n(0, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         e_done = (i == exp_q.size() - 1);
         vectors++;
         if (level !== LW'(exp_q[i]) || grp_en !== therm(exp_q[i]) || busy !== 1'b1 || done !== e_done) begin
            fails++;
            $display("FAIL clamp[%0d]: level=%0d grp_en=%h busy=%b done=%b, want %0d %h 1 %b",
                     i, level, grp_en, busy, done, exp_q[i], therm(exp_q[i]), e_done);
         end
         if (exp_q[i] == 16) begin
            vectors++;
            if (grp_en !== 16'hFFFF) begin
               fails++;
               $display("FAIL clamp_peak: grp_en=%h, want ffff", grp_en);
            end
         end
         tick();
      end
      vectors++;
      if (busy !== 1'b0 || level !== '0) begin
         fails++;
         $display("FAIL clamp_end: busy=%b level=%0d, want 0 0", busy, level);
      end
   endtask

   task automatic test_abort_hold();
      logic e_done;
      set_cfg(4, 2, 2, 6, 3, 1'b0);
      push_n(2, 2);
      push_n(4, 3);
      push_n(2, 2);
      push_n(0, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         e_done = (i == exp_q.size() - 1);
         vectors++;
         if (level !== LW'(exp_q[i]) || grp_en !== therm(exp_q[i]) || busy !== 1'b1 || done !== e_done) begin
            fails++;
            $display("FAIL abort_hold[%0d]: level=%0d grp_en=%h busy=%b done=%b, want %0d %h 1 %b",
                     i, level, grp_en, busy, done, exp_q[i], therm(exp_q[i]), e_done);
         end
         if (i == 4) begin
            vectors++;
            if (status_led !== 4'b1011) begin
               fails++;
               $display("FAIL abort_led: led=%b, want 1011", status_led);
            end
         end
         abort = (i == 3);
         tick();
      end
      abort = 1'b0;
      for (int i = 0; i < 10; i++) begin
         vectors++;
         if (busy !== 1'b0 || done !== 1'b0 || level !== '0) begin
            fails++;
            $display("FAIL abort_quiet[%0d]: busy=%b done=%b level=%0d, want 0 0 0", i, busy, done, level);
         end
         tick();
      end
   endtask

   task automatic test_zero_target();
      set_cfg(0, 3, 4, 4, 2, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      vectors++;
      if (level !== '0 || busy !== 1'b1 || done !== 1'b1 || status_led !== 4'b1000) begin
         fails++;
         $display("FAIL zero_done: level=%0d busy=%b done=%b led=%b, want 0 1 1 1000",
                  level, busy, done, status_led);
      end
      tick();
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || status_led !== 4'b0100) begin
         fails++;
         $display("FAIL zero_idle: busy=%b done=%b led=%b, want 0 0 0100", busy, done, status_led);
      end
   endtask

   task automatic test_start_abort();
      logic e_done;
      set_cfg(2, 2, 1, 1, 2, 1'b0);
      exp_q = '{2, 0, 2, 0};
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         e_done = (i == exp_q.size() - 1);
         vectors++;
         if (level !== LW'(exp_q[i]) || busy !== 1'b1 || done !== e_done) begin
            fails++;
            $display("FAIL start_abort[%0d]: level=%0d busy=%b done=%b, want %0d 1 %b",
                     i, level, busy, done, exp_q[i], e_done);
         end
         tick();
      end
   endtask

   task automatic test_reset_midrun();
      logic e_done;
      set_cfg(16, 1, 1, 1, 1, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      vectors++;
      if (level !== LW'(7)) begin
         fails++;
         $display("FAIL midrun_level: level=%0d, want 7", level);
      end
      rst_n = 1'b0;
      tick();
      vectors++;
      if (level !== '0 || grp_en !== '0 || busy !== 1'b0 || done !== 1'b0 || status_led !== 4'b0000) begin
         fails++;
         $display("FAIL midrun_reset: level=%0d grp_en=%h busy=%b done=%b led=%b, want all zero",
                  level, grp_en, busy, done, status_led);
      end
      rst_n = 1'b1;
      tick();
      set_cfg(3, 1, 2, 1, 1, 1'b0);
      exp_q = '{1, 1, 2, 2, 3, 2, 2, 1, 1, 0};
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         e_done = (i == exp_q.size() - 1);
         vectors++;
         if (level !== LW'(exp_q[i]) || grp_en !== therm(exp_q[i]) || busy !== 1'b1 || done !== e_done) begin
            fails++;
            $display("FAIL fresh[%0d]: level=%0d grp_en=%h busy=%b done=%b, want %0d %h 1 %b",
                     i, level, grp_en, busy, done, exp_q[i], therm(exp_q[i]), e_done);
         end
         tick();
      end
   endtask

   task automatic test_pulse();
      logic e_done;
      set_cfg(12, 1, 3, 5, 2, 1'b1);
`ifdef PWR_SEQ_PULSE_EN
      push_n(12, 5);
      push_n(0, 3);
      push_n(12, 5);
      push_n(0, 1);
`else
      push_walk(1, 11, 1, 3);
      push_n(12, 5);
      push_walk(11, 1, -1, 3);
      push_n(0, 3);
      push_walk(1, 11, 1, 3);
      push_n(12, 5);
      push_walk(11, 1, -1, 3);
      push_n(0, 1);
`endif
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         e_done = (i == exp_q.size() - 1);
         vectors++;
         if (level !== LW'(exp_q[i]) || grp_en !== therm(exp_q[i]) || busy !== 1'b1 || done !== e_done) begin
            fails++;
            $display("FAIL pulse[%0d]: level=%0d grp_en=%h busy=%b done=%b, want %0d %h 1 %b",
                     i, level, grp_en, busy, done, exp_q[i], therm(exp_q[i]), e_done);
         end
         tick();
      end
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL pulse_end: busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_clamp();
      test_abort_hold();
      test_zero_target();
      test_start_abort();
      test_reset_midrun();
      test_pulse();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
